// File: rtl/ring_ct_pkg.sv
`default_nettype none
// ============================================================================
// Module : ring_ct_pkg
// Brief  : Shared sizes, FSM state encoding, forbidden ring-loop masks and
//          the round-robin picker for the ring contactor sequencer.
// Rev    : 1.0  initial release
// ============================================================================
package ring_ct_pkg;

  localparam int N_CT      = 8;
  localparam int c_IDX_W   = $clog2(N_CT);
  localparam int c_N_MASKS = 7;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ARB        = 3'd1,
    ST_CLOSE_WAIT = 3'd2,
    ST_OPEN_WAIT  = 3'd3,
    ST_SETTLE     = 3'd4,
    ST_FAULT      = 3'd5
  } state_t;

  // Each mask is a set of contactors that together close a loop of the ring;
  // all members of any one mask must never be closed at the same time.
  // Entry 0 is the rightmost element.
  localparam logic [c_N_MASKS-1:0][N_CT-1:0] RING_FORBIDDEN_MASKS =
    {8'h87, 8'hAD, 8'h6A, 8'hB0, 8'h1B, 8'hC1, 8'h07};

  // First set bit of req found scanning upward from ptr, wrapping around.
  function automatic logic [c_IDX_W-1:0] rr_pick(input logic [N_CT-1:0]    req,
                                                 input logic [c_IDX_W-1:0] ptr);
    logic [c_IDX_W-1:0] pick;
    logic [c_IDX_W-1:0] idx;
    logic               found;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < N_CT; i++) begin
      idx = c_IDX_W'((int'(ptr) + i) % N_CT);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ring_interlock_check.sv
`default_nettype none
// ============================================================================
// Module : ring_interlock_check
// Brief  : Combinational interlock. Closing candidate i_idx is refused when,
//          together with the confirmed-closed set, it would complete any
//          forbidden ring loop that contains the candidate.
// Rev    : 1.0  initial release
// ============================================================================
module ring_interlock_check
  import ring_ct_pkg::*;
(
  input  logic [N_CT-1:0]    i_closed,
  input  logic [c_IDX_W-1:0] i_idx,
  output logic               o_allow
);

  logic [N_CT-1:0]      w_trial;
  logic [c_N_MASKS-1:0] w_hit;

  assign w_trial = i_closed | (N_CT'(1) << i_idx);

  generate
    for (genvar g = 0; g < c_N_MASKS; g++) begin : g_mask
      localparam logic [N_CT-1:0] c_MASK = RING_FORBIDDEN_MASKS[g];
      assign w_hit[g] = c_MASK[i_idx] && ((w_trial & c_MASK) == c_MASK);
    end
  endgenerate

  assign o_allow = ~|w_hit;

endmodule
`default_nettype wire

// File: rtl/ring_contactor_sequencer.sv
`default_nettype none
// ============================================================================
// Module : ring_contactor_sequencer
// Brief  : One-at-a-time close/open sequencer for the ring contactors with
//          round-robin arbitration, loop interlock, feedback confirmation,
//          timeout/supervision faults and emergency trip.
// Rev    : 1.0  initial release
// ============================================================================
module ring_contactor_sequencer
  import ring_ct_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1000,
  parameter int SETTLE_CYC  = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [N_CT-1:0]    i_close_req,
  input  logic [N_CT-1:0]    i_open_req,
  input  logic [N_CT-1:0]    i_fb,
  input  logic               i_trip,
  input  logic               i_fault_clr,
  output logic [N_CT-1:0]    o_cmd,
  output logic               o_busy,
  output logic [N_CT-1:0]    o_deny,
  output logic               o_done,
  output logic               o_fault,
  output logic [c_IDX_W-1:0] o_fault_idx
);

  localparam int                 c_TMR_W    = $clog2(TIMEOUT_CYC + 1);
  localparam int                 c_STL_W    = $clog2(SETTLE_CYC + 1);
  localparam logic [c_TMR_W-1:0] c_TMR_MAX  = c_TMR_W'(TIMEOUT_CYC);
  localparam logic [c_STL_W-1:0] c_STL_LAST = c_STL_W'(SETTLE_CYC - 1);

  state_t               r_state, w_state_nxt;
  logic [N_CT-1:0]      r_cmd, r_deny;
  logic                 r_done, r_all;
  logic [c_IDX_W-1:0]   r_idx, r_rr, r_fault_idx;
  logic [c_TMR_W-1:0]   r_timer;
  logic [c_STL_W-1:0]   r_stl_cnt;

  logic [N_CT-1:0]      w_pend_open, w_pend_close, w_sup_trip;
  logic [c_IDX_W-1:0]   w_win, w_rr_nxt, w_sup_idx, w_low_fb, w_fault_idx_nxt;
  logic [c_TMR_W-1:0]   w_timer_inc;
  logic                 w_allow, w_match, w_timeout;
  logic                 w_trip_go, w_open_go, w_close_go, w_deny_go, w_done_go, w_fault_go;

  // An open is pending only on a commanded-closed contactor; open beats close.
  assign w_pend_open  = i_open_req & r_cmd;
  assign w_pend_close = i_close_req & ~i_open_req & ~r_cmd;
  assign w_win        = (|w_pend_open) ? rr_pick(w_pend_open, r_rr) : rr_pick(w_pend_close, r_rr);
  assign w_rr_nxt     = (w_win == c_IDX_W'(N_CT - 1)) ? '0 : w_win + 1'b1;

  ring_interlock_check u_interlock (
    .i_closed (r_cmd & i_fb),
    .i_idx    (w_win),
    .o_allow  (w_allow)
  );

  // After a trip the whole ring must read open; otherwise only the active contactor.
  assign w_match     = r_all ? (i_fb == '0) : (i_fb[r_idx] == r_cmd[r_idx]);
  assign w_timer_inc = (r_timer == c_TMR_MAX) ? r_timer : r_timer + 1'b1;
  assign w_timeout   = (w_timer_inc >= c_TMR_MAX);

  // Idle supervision: count consecutive feedback/command disagreement per contactor.
  generate
    for (genvar k = 0; k < N_CT; k++) begin : g_sup
      logic [c_STL_W-1:0] r_cnt;
      assign w_sup_trip[k] = (i_fb[k] != r_cmd[k]) && (r_cnt == c_STL_LAST);
      // Counter runs only while idle and mismatched; any other condition clears it.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                                      r_cnt <= '0;
        else if (r_state == ST_IDLE && i_fb[k] != r_cmd[k]) r_cnt <= (r_cnt == c_STL_LAST) ? r_cnt : r_cnt + 1'b1;
        else                                               r_cnt <= '0;
      end
    end
  endgenerate

  // Lowest-index selection for supervision faults and trip-timeout faults.
  always_comb begin
    w_sup_idx = '0;
    w_low_fb  = '0;
    for (int k = N_CT - 1; k >= 0; k--) begin
      if (w_sup_trip[k]) w_sup_idx = c_IDX_W'(k);
      if (i_fb[k])       w_low_fb  = c_IDX_W'(k);
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic and the one-cycle action strobes for the datapath.
  always_comb begin
    w_state_nxt     = r_state;
    w_trip_go       = 1'b0;
    w_open_go       = 1'b0;
    w_close_go      = 1'b0;
    w_deny_go       = 1'b0;
    w_done_go       = 1'b0;
    w_fault_go      = 1'b0;
    w_fault_idx_nxt = r_idx;
    if (i_trip) begin
      w_trip_go   = 1'b1;
      w_state_nxt = ST_OPEN_WAIT;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_sup_trip) begin
            w_fault_go      = 1'b1;
            w_fault_idx_nxt = w_sup_idx;
            w_state_nxt     = ST_FAULT;
          end else if (|(w_pend_open | w_pend_close)) begin
            w_state_nxt = ST_ARB;
          end
        end
        ST_ARB: begin
          w_state_nxt = ST_IDLE;
          if (|w_pend_open) begin
            w_open_go   = 1'b1;
            w_state_nxt = ST_OPEN_WAIT;
          end else if (|w_pend_close) begin
            if (w_allow) begin
              w_close_go  = 1'b1;
              w_state_nxt = ST_CLOSE_WAIT;
            end else begin
              w_deny_go = 1'b1;
            end
          end
        end
        ST_CLOSE_WAIT, ST_OPEN_WAIT: begin
          if (w_match) begin
            w_state_nxt = ST_SETTLE;
          end else if (w_timeout) begin
            w_fault_go      = 1'b1;
            w_fault_idx_nxt = r_all ? w_low_fb : r_idx;
            w_state_nxt     = ST_FAULT;
          end
        end
        ST_SETTLE: begin
          if (!w_match) begin
            w_state_nxt = (!r_all && r_cmd[r_idx]) ? ST_CLOSE_WAIT : ST_OPEN_WAIT;
          end else if (r_stl_cnt == c_STL_LAST) begin
            w_done_go   = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        ST_FAULT: begin
          if (i_fault_clr) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Datapath: coil commands, rr pointer, timers and registered pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cmd       <= '0;
      r_deny      <= '0;
      r_done      <= 1'b0;
      r_all       <= 1'b0;
      r_idx       <= '0;
      r_rr        <= '0;
      r_fault_idx <= '0;
      r_timer     <= '0;
      r_stl_cnt   <= '0;
    end else begin
      r_deny    <= '0;
      r_done    <= w_done_go;
      r_stl_cnt <= (r_state == ST_SETTLE && w_match && !w_done_go) ? r_stl_cnt + 1'b1 : '0;
      if (w_trip_go) begin
        r_cmd   <= '0;
        r_all   <= 1'b1;
        r_timer <= '0;
      end else begin
        if (w_open_go || w_close_go) begin
          r_cmd[w_win] <= w_close_go;
          r_idx        <= w_win;
          r_all        <= 1'b0;
          r_timer      <= '0;
        end
        if (w_open_go || w_close_go || w_deny_go) r_rr <= w_rr_nxt;
        if (w_deny_go) r_deny <= N_CT'(1) << w_win;
        if ((r_state == ST_CLOSE_WAIT || r_state == ST_OPEN_WAIT) && !w_match) r_timer <= w_timer_inc;
        if (r_state == ST_FAULT) r_cmd[r_fault_idx] <= 1'b0;
        if (w_fault_go) begin
          r_fault_idx            <= w_fault_idx_nxt;
          r_cmd[w_fault_idx_nxt] <= 1'b0;
        end
      end
    end
  end

  // Status outputs decoded from state; everything else straight from registers.
  always_comb begin
    o_busy  = (r_state != ST_IDLE);
    o_fault = (r_state == ST_FAULT);
  end

  assign o_cmd       = r_cmd;
  assign o_deny      = r_deny;
  assign o_done      = r_done;
  assign o_fault_idx = r_fault_idx;

endmodule
`default_nettype wire

// File: tb/tb_ring_contactor_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_ring_contactor_sequencer
// Brief  : Directed and randomized self-checking bench for the ring contactor
//          sequencer with a transaction-level reference model and a simple
//          feedback plant (delayed copy of the coil command).
// Rev    : 1.0  initial release
// ============================================================================
module tb_ring_contactor_sequencer;

  localparam int c_TO = 1000;
  localparam int c_ST = 16;
  localparam logic [7:0] c_MASKS [7] = '{8'h07, 8'hC1, 8'h1B, 8'hB0, 8'h6A, 8'hAD, 8'h87};

  logic       clk = 1'b0;
  logic       i_rst_n, i_trip, i_fault_clr;
  logic [7:0] i_close_req, i_open_req, i_fb;
  logic [7:0] o_cmd, o_deny;
  logic       o_busy, o_done, o_fault;
  logic [2:0] o_fault_idx;

  ring_contactor_sequencer #(.TIMEOUT_CYC(c_TO), .SETTLE_CYC(c_ST)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_close_req(i_close_req), .i_open_req(i_open_req),
    .i_fb(i_fb), .i_trip(i_trip), .i_fault_clr(i_fault_clr), .o_cmd(o_cmd), .o_busy(o_busy),
    .o_deny(o_deny), .o_done(o_done), .o_fault(o_fault), .o_fault_idx(o_fault_idx)
  );

  always #5 clk = ~clk;

  int         total = 0, bad = 0, cyc = 0;
  int         done_cnt, deny_cnt;
  logic [7:0] deny_acc;
  logic [7:0] hist [8];
  logic [7:0] fb_force;
  bit         plant_on;
  int         plant_dly;
  logic [7:0] m_cmd;
  int         m_rr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, sample just after the edge, and update the plant.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = o_cmd;
    i_fb = plant_on ? hist[plant_dly-1] : fb_force;
    if (o_done) done_cnt++;
    if (o_deny != 0) begin
      deny_cnt++;
      deny_acc |= o_deny;
    end
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0; i_close_req = '0; i_open_req = '0; i_trip = 1'b0; i_fault_clr = 1'b0;
    plant_on = 1'b1; plant_dly = 1; fb_force = '0; i_fb = '0;
    for (int i = 0; i < 8; i++) hist[i] = '0;
    repeat (2) tick();
    i_rst_n = 1'b1;
    tick();
    m_cmd = '0; m_rr = 0;
  endtask

  function automatic bit forbidden(input logic [7:0] closed, input int k);
    logic [7:0] t, mm;
    t = closed | (8'd1 << k);
    for (int m = 0; m < 7; m++) begin
      mm = c_MASKS[m];
      if (mm[k] && ((t & mm) == mm)) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int first_from(input logic [7:0] v, input int start);
    for (int i = 0; i < 8; i++) if (v[(start + i) % 8]) return (start + i) % 8;
    return -1;
  endfunction

  // One arbitration of the reference model: opens first, then closes, each round-robin.
  task automatic predict(input logic [7:0] cr, input logic [7:0] orq,
                         output logic [7:0] e_deny, output int e_done, output bit act);
    logic [7:0] po, pc;
    int w;
    po = orq & m_cmd;
    pc = cr & ~orq & ~m_cmd;
    e_deny = '0; e_done = 0; act = 1'b0;
    if (po != 0) begin
      w = first_from(po, m_rr);
      m_cmd[w] = 1'b0; m_rr = (w + 1) % 8; e_done = 1; act = 1'b1;
    end else if (pc != 0) begin
      w = first_from(pc, m_rr);
      m_rr = (w + 1) % 8; act = 1'b1;
      if (forbidden(m_cmd, w)) e_deny = 8'd1 << w;
      else begin
        m_cmd[w] = 1'b1; e_done = 1;
      end
    end
  endtask

  // Present requests until the first arbitration outcome, then let the operation finish.
  task automatic run_op(input logic [7:0] cr, input logic [7:0] orq, input string tag);
    logic [7:0] start, e_deny;
    int e_done, n;
    bit act;
    start = o_cmd;
    predict(cr, orq, e_deny, e_done, act);
    done_cnt = 0; deny_cnt = 0; deny_acc = '0;
    i_close_req = cr; i_open_req = orq;
    n = 0;
    if (act) while (o_cmd == start && deny_cnt == 0 && n < 20) begin tick(); n++; end
    else repeat (3) tick();
    i_close_req = '0; i_open_req = '0;
    n = 0;
    while (o_busy && n < 3000) begin tick(); n++; end
    repeat (3) tick();
    chk({tag, "_cmd"}, o_cmd, m_cmd);
    chk({tag, "_deny"}, deny_acc, e_deny);
    chk({tag, "_deny_pulses"}, deny_cnt, (e_deny != 0) ? 1 : 0);
    chk({tag, "_done"}, done_cnt, e_done);
    chk({tag, "_fault"}, o_fault, 0);
    chk({tag, "_busy"}, o_busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t_fb, t_done, t0, dt;
    logic [7:0] first;
    logic [7:0] cr, orq;

    // Reset state, sampled while reset is held.
    i_rst_n = 1'b0; i_close_req = '0; i_open_req = '0; i_trip = 1'b0; i_fault_clr = 1'b0;
    plant_on = 1'b1; plant_dly = 1; fb_force = '0; i_fb = '0;
    for (int i = 0; i < 8; i++) hist[i] = '0;
    repeat (2) tick();
    chk("rst_cmd", o_cmd, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_deny", o_deny, 0);
    chk("rst_done", o_done, 0);
    chk("rst_fault", o_fault, 0);
    chk("rst_fault_idx", o_fault_idx, 0);
    do_reset();

    // Single close with feedback following 5 cycles later.
    plant_dly = 5; done_cnt = 0; t_fb = -1; t_done = -1; n = 0;
    i_close_req = 8'h01;
    while (t_done < 0 && n < 200) begin
      tick(); n++;
      if (i_fb[0] && t_fb < 0) t_fb = cyc;
      if (o_done && t_done < 0) t_done = cyc;
    end
    i_close_req = '0;
    repeat (5) tick();
    chk("t1_cmd", o_cmd, 8'h01);
    chk("t1_done_once", done_cnt, 1);
    chk("t1_fault", o_fault, 0);
    chk("t1_settle_window", (t_fb >= 0 && t_done - t_fb >= c_ST && t_done - t_fb <= c_ST + 2), 1);
    m_cmd = 8'h01; m_rr = 1;

    // Interlock: A,B closed, C would complete loop 8'h07.
    plant_dly = 1;
    run_op(8'h02, 8'h00, "t2_close_b");
    run_op(8'h04, 8'h00, "t2_interlock");

    // Round-robin from pointer 0 with 1 and 4 requested together.
    do_reset();
    plant_dly = 2; done_cnt = 0; first = '0; n = 0;
    i_close_req = 8'h12;
    while (done_cnt < 2 && n < 500) begin
      tick(); n++;
      if (first == 0 && o_cmd != 0) first = o_cmd;
    end
    i_close_req = '0;
    repeat (3) tick();
    chk("t3_first_grant", first, 8'h02);
    chk("t3_final_cmd", o_cmd, 8'h12);
    chk("t3_done_cnt", done_cnt, 2);
    m_cmd = 8'h12; m_rr = 5;
    run_op(8'h21, 8'h00, "t3_rr_after");

    // Randomized traffic against the reference model.
    for (int i = 0; i < 30; i++) begin
      plant_dly = $urandom_range(1, 8);
      cr  = 8'($urandom);
      orq = 8'($urandom & $urandom & $urandom);
      run_op(cr, orq, "rand");
    end

    // Timeout on close of D with feedback stuck open.
    do_reset();
    plant_on = 1'b0; fb_force = '0;
    tick();
    i_close_req = 8'h08; n = 0;
    while (!o_cmd[3] && n < 20) begin tick(); n++; end
    t0 = cyc;
    i_close_req = '0; n = 0;
    while (!o_fault && n < c_TO + 50) begin tick(); n++; end
    dt = cyc - t0;
    chk("t4_timeout_window", (dt >= c_TO - 1 && dt <= c_TO + 2), 1);
    chk("t4_fault", o_fault, 1);
    chk("t4_fault_idx", o_fault_idx, 3);
    chk("t4_cmd", o_cmd, 0);
    i_close_req = 8'h01;
    repeat (4) tick();
    i_close_req = '0;
    chk("t4_req_ignored", o_cmd, 0);
    chk("t4_fault_held", o_fault, 1);
    i_fault_clr = 1'b1;
    tick();
    i_fault_clr = 1'b0;
    chk("t4_fault_cleared", o_fault, 0);
    repeat (2) tick();
    chk("t4_idle", o_busy, 0);

    // Trip while F is closing with A already closed.
    do_reset();
    run_op(8'h01, 8'h00, "t5_pre");
    plant_on = 1'b0; fb_force = 8'h01;
    i_close_req = 8'h20; n = 0;
    while (o_cmd != 8'h21 && n < 20) begin tick(); n++; end
    i_close_req = '0;
    repeat (2) tick();
    chk("t5_cmd_before_trip", o_cmd, 8'h21);
    chk("t5_busy_before_trip", o_busy, 1);
    i_trip = 1'b1;
    tick();
    i_trip = 1'b0;
    chk("t5_cmd_after_trip", o_cmd, 0);
    repeat (3) tick();
    fb_force = '0; n = 0;
    while (o_busy && n < 100) begin tick(); n++; end
    chk("t5_idle", o_busy, 0);
    chk("t5_no_fault", o_fault, 0);

    // Spurious open of G while idle.
    do_reset();
    run_op(8'h40, 8'h00, "t6_pre");
    plant_on = 1'b0; fb_force = 8'h40;
    tick();
    fb_force = '0;
    tick();
    repeat (c_ST - 3) tick();
    chk("t6_no_early_fault", o_fault, 0);
    n = 0;
    while (!o_fault && n < 10) begin tick(); n++; end
    chk("t6_fault", o_fault, 1);
    chk("t6_fault_idx", o_fault_idx, 6);
    chk("t6_cmd", o_cmd, 0);

    // Asynchronous reset during settle drops everything without a clock edge.
    do_reset();
    plant_dly = 2;
    i_close_req = 8'h01; n = 0;
    while (!(o_busy && i_fb[0]) && n < 30) begin tick(); n++; end
    i_close_req = '0;
    repeat (2) tick();
    chk("t7_in_settle", o_busy, 1);
    #2 i_rst_n = 1'b0;
    #1;
    chk("t7_async_cmd", o_cmd, 0);
    chk("t7_async_busy", o_busy, 0);
    chk("t7_async_done", o_done, 0);
    chk("t7_async_fault", o_fault, 0);
    chk("t7_async_deny", o_deny, 0);
    tick();
    i_rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
